// File: rtl/spi_transaction_scheduler.sv
// spi_transaction_scheduler: round-robin sharing of one SPI controller among clients.
// Optional WAIT timeout enabled by defining SPI_SCHED_TIMEOUT_EN.

package spi_sched_pkg;

    typedef enum logic [2:0] {
        SPI_STATUS       = 3'd0,
        SPI_SLAVE_SELECT = 3'd1,
        SPI_EVENT        = 3'd2,
        SPI_TX_BUFFER    = 3'd3,
        SPI_RX_BUFFER    = 3'd4
    } spi_registers_t;

endpackage

module spi_transaction_scheduler
    import spi_sched_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int SLAVES     = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [REQUESTERS-1:0]               req_valid_i,
    input  logic [REQUESTERS-1:0][SLAVES-1:0]   req_slave_i,
    input  logic [REQUESTERS-1:0][4:0]          req_length_i,
    output logic [REQUESTERS-1:0]               req_ready_o,
    input  logic [REQUESTERS-1:0][7:0]          tx_data_i,
    input  logic [REQUESTERS-1:0]               tx_valid_i,
    output logic [REQUESTERS-1:0]               tx_ready_o,
    output logic [7:0]                          rx_data_o,
    output logic [REQUESTERS-1:0]               rx_valid_o,
    output logic [REQUESTERS-1:0]               done_o,
    output logic                                error_o,
    output logic                                write_o,
    output spi_registers_t                      write_address_o,
    output logic [31:0]                         write_data_o,
    output logic [3:0]                          write_strobe_o,
    input  logic                                write_error_i,
    output logic                                read_o,
    output spi_registers_t                      read_address_o,
    input  logic [31:0]                         read_data_i,
    input  logic                                read_error_i,
    input  logic                                interrupt_i
);

    localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_CLEAR    = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;
    localparam logic [2:0] S_DESELECT = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CYCLES = 16'hFFFF;
    logic [15:0] tmo_q, tmo_d;
`endif

    logic [2:0]            state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [SLAVES-1:0]     slave_q, slave_d;
    logic [4:0]            len_q, len_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  rx_pend_q, rx_pend_d;

    logic                  win_found;
    logic [PW-1:0]         win_idx;
    logic [SLAVES-1:0]     sel_slave;
    logic [4:0]            sel_len;
    logic                  slave_ok;
    logic                  req_ok;
    logic [REQUESTERS-1:0] own_oh;
    logic                  unused_rd;

    assign unused_rd = ^read_data_i[31:8];
    assign own_oh    = REQUESTERS'(1) << owner_q;
    assign write_strobe_o = '1;
    assign rx_valid_o = rx_pend_q ? own_oh : '0;
    assign rx_data_o  = rx_pend_q ? read_data_i[7:0] : 8'h00;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        int k;
        logic [PW-1:0] kk;
        win_found = 1'b0;
        win_idx   = '0;
        k         = 0;
        kk        = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            k = int'(ptr_q) + i;
            if (k >= REQUESTERS) begin
                k = k - REQUESTERS;
            end
            kk = PW'(k);
            if (!win_found && req_valid_i[kk]) begin
                win_found = 1'b1;
                win_idx   = kk;
            end
        end
    end

    // Validate the winning request before any SPI access is made.
    always_comb begin
        sel_slave = req_slave_i[win_idx];
        sel_len   = req_length_i[win_idx];
        slave_ok  = (sel_slave != '0) &&
                    ((sel_slave & (sel_slave - SLAVES'(1))) == '0);
        req_ok    = slave_ok && (sel_len != 5'd0) &&
                    (sel_len <= 5'(MAX_BURST));
    end

    // Transaction sequencer and SPI register port drive.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        slave_d   = slave_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rx_pend_d = 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
        tmo_d     = 16'd0;
`endif
        req_ready_o     = '0;
        tx_ready_o      = '0;
        done_o          = '0;
        error_o         = 1'b0;
        write_o         = 1'b0;
        write_address_o = SPI_STATUS;
        write_data_o    = 32'h0;
        read_o          = 1'b0;
        read_address_o  = SPI_STATUS;

        unique case (state_q)
            S_IDLE: begin
                if (win_found && rst_n_i) begin
                    req_ready_o[win_idx] = 1'b1;
                    owner_d = win_idx;
                    slave_d = sel_slave;
                    len_d   = sel_len;
                    cnt_d   = 5'd0;
                    err_d   = !req_ok;
                    state_d = req_ok ? S_SELECT : S_DONE;
                end
            end
            S_SELECT: begin
                write_o         = 1'b1;
                write_address_o = SPI_SLAVE_SELECT;
                write_data_o    = 32'(slave_q);
                if (write_error_i) begin
                    err_d   = 1'b1;
                    state_d = S_DESELECT;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (tx_valid_i[owner_q]) begin
                    write_o         = 1'b1;
                    write_address_o = SPI_TX_BUFFER;
                    write_data_o    = {24'h0, tx_data_i[owner_q]};
                    tx_ready_o      = own_oh;
                    cnt_d           = cnt_q + 5'd1;
                    if (write_error_i) begin
                        err_d   = 1'b1;
                        state_d = S_DESELECT;
                    end else if (cnt_d == len_q) begin
                        cnt_d   = 5'd0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
`ifdef SPI_SCHED_TIMEOUT_EN
                tmo_d = tmo_q + 16'd1;
                if (interrupt_i) begin
                    state_d = S_CLEAR;
                end else if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
                    err_d   = 1'b1;
                    state_d = S_DESELECT;
                end
`else
                if (interrupt_i) begin
                    state_d = S_CLEAR;
                end
`endif
            end
            S_CLEAR: begin
                write_o         = 1'b1;
                write_address_o = SPI_EVENT;
                cnt_d           = 5'd0;
                if (write_error_i) begin
                    err_d   = 1'b1;
                    state_d = S_DESELECT;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                read_o         = 1'b1;
                read_address_o = SPI_RX_BUFFER;
                if (read_error_i) begin
                    err_d   = 1'b1;
                    state_d = S_DESELECT;
                end else begin
                    rx_pend_d = 1'b1;
                    cnt_d     = cnt_q + 5'd1;
                    if (cnt_d == len_q) begin
                        state_d = S_DESELECT;
                    end
                end
            end
            S_DESELECT: begin
                write_o         = 1'b1;
                write_address_o = SPI_SLAVE_SELECT;
                if (write_error_i) begin
                    err_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = own_oh;
                error_o = err_q;
                ptr_d   = (owner_q == PW'(REQUESTERS - 1)) ?
                          '0 : owner_q + PW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops straight to IDLE without a deselect.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            slave_q   <= '0;
            len_q     <= 5'd0;
            cnt_q     <= 5'd0;
            err_q     <= 1'b0;
            rx_pend_q <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
            tmo_q     <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            slave_q   <= slave_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rx_pend_q <= rx_pend_d;
`ifdef SPI_SCHED_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_transaction_scheduler.sv
// tb_spi_transaction_scheduler: scoreboard bench with a loopback SPI register model.
// Timeout scenario runs only when SPI_SCHED_TIMEOUT_EN is defined.

module tb_spi_transaction_scheduler;
    import spi_sched_pkg::*;

    localparam int R = 4;
    localparam int S = 1;
    localparam int EV_G  = 0;
    localparam int EV_RX = 1;
    localparam int EV_D  = 2;

    typedef struct {
        int kind;
        int idx;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [R-1:0]          req_valid;
    logic [R-1:0][S-1:0]   req_slave;
    logic [R-1:0][4:0]     req_length;
    logic [R-1:0]          req_ready;
    logic [R-1:0][7:0]     tx_data;
    logic [R-1:0]          tx_valid;
    logic [R-1:0]          tx_ready;
    logic [7:0]            rx_data;
    logic [R-1:0]          rx_valid;
    logic [R-1:0]          done;
    logic                  error;
    logic                  write;
    spi_registers_t        waddr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  werr;
    logic                  read;
    spi_registers_t        raddr;
    logic [31:0]           rdata = 32'h0;
    logic                  rerr;
    logic                  irq = 1'b0;

    always #5 clk = ~clk;

    spi_transaction_scheduler #(
        .REQUESTERS(R), .SLAVES(S), .MAX_BURST(16)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_slave_i(req_slave),
        .req_length_i(req_length), .req_ready_o(req_ready),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .done_o(done), .error_o(error),
        .write_o(write), .write_address_o(waddr),
        .write_data_o(wdata), .write_strobe_o(wstrb),
        .write_error_i(werr),
        .read_o(read), .read_address_o(raddr),
        .read_data_i(rdata), .read_error_i(rerr),
        .interrupt_i(irq)
    );

    int n_chk = 0;
    int n_fail = 0;
    ev_t sb[$];

    int n_acc = 0;
    int tx_viol = 0;
    int tx_wr_cnt = 0;
    int inj_base = 0;
    logic inj_en = 1'b0;
    logic irq_en = 1'b1;
    int sel_last = 0;
    int busy = 0;
    logic [7:0] loop_q[$];

    logic s_w = 1'b0, s_r = 1'b0, s_werr = 1'b0;
    spi_registers_t s_a = SPI_STATUS;
    logic [31:0] s_d = 32'h0;

    logic [7:0] txq[R][$];
    int req_cnt[R], acc_cnt[R], pops[R];
    int stall_at[R], stall_len[R], stalled[R];
    logic [S-1:0] p_slave[R];
    logic [4:0] p_len[R];

    assign werr = inj_en && write && (waddr == SPI_TX_BUFFER) &&
                  (tx_wr_cnt == inj_base + 2);
    assign rerr = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [R-1:0] v);
        for (int i = 0; i < R; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic expect_ev(input string nm, input int kind,
                             input int idx, input int val);
        ev_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: unexpected event idx %0d val %0d, none expected",
                     nm, idx, val);
        end else begin
            e = sb.pop_front();
            chk({nm, "_kind"}, kind, e.kind);
            chk({nm, "_idx"}, idx, e.idx);
            chk({nm, "_val"}, val, e.val);
        end
    endtask

    // Monitor: compare DUT events against the scoreboard, snapshot SPI port
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0) begin
                chk("grant_onehot", $countones(req_ready), 1);
                expect_ev("grant", EV_G, oh2i(req_ready), 0);
            end
            if (rx_valid != '0)
                expect_ev("rx", EV_RX, oh2i(rx_valid), int'(rx_data));
            if (done != '0)
                expect_ev("done", EV_D, oh2i(done), int'(error));
            if (write && waddr == SPI_TX_BUFFER && tx_ready == '0)
                tx_viol++;
            if (write || read) n_acc++;
            s_w = write; s_r = read; s_werr = werr;
            s_a = waddr; s_d = wdata;
        end else begin
            s_w = 1'b0; s_r = 1'b0; s_werr = 1'b0;
        end
    end

    // SPI controller model: TX bytes loop back to RX, irq after idle gap
    always @(posedge clk) begin
        if (!rst_n) begin
            irq <= 1'b0;
            busy = 0;
        end else begin
            if (busy > 0) begin
                busy--;
                if (busy == 0 && irq_en) irq <= 1'b1;
            end
            if (s_w) begin
                if (s_a == SPI_TX_BUFFER) begin
                    tx_wr_cnt++;
                    if (!s_werr) begin
                        loop_q.push_back(s_d[7:0]);
                        busy = 12;
                    end
                end else if (s_a == SPI_EVENT && !s_werr) begin
                    irq <= 1'b0;
                end else if (s_a == SPI_SLAVE_SELECT && !s_werr) begin
                    sel_last = int'(s_d);
                    if (s_d != 0) begin
                        loop_q.delete();
                        irq <= 1'b0;
                    end
                end
            end
            if (s_r)
                rdata <= (loop_q.size() > 0) ?
                         {24'hA5A5A5, loop_q.pop_front()} : 32'hA5A5A500;
        end
    end

    // Client driver: holds requests until accepted, feeds TX bytes
    initial begin
        logic [R-1:0] rr, tr;
        req_valid = '0; req_slave = '0; req_length = '0;
        tx_valid = '0; tx_data = '0;
        for (int c = 0; c < R; c++) begin
            req_cnt[c] = 0; acc_cnt[c] = 0; pops[c] = 0;
            stall_at[c] = -1; stall_len[c] = 0; stalled[c] = 0;
            p_slave[c] = '0; p_len[c] = '0;
        end
        forever begin
            @(negedge clk);
            rr = req_ready;
            tr = tx_ready;
            @(posedge clk);
            #1;
            for (int c = 0; c < R; c++) begin
                if (rr[c]) acc_cnt[c]++;
                if (tr[c] && txq[c].size() > 0) begin
                    void'(txq[c].pop_front());
                    pops[c]++;
                end
                req_valid[c]  = (req_cnt[c] != acc_cnt[c]);
                req_slave[c]  = p_slave[c];
                req_length[c] = p_len[c];
                if (pops[c] != stall_at[c]) stalled[c] = 0;
                if (txq[c].size() > 0 && pops[c] == stall_at[c] &&
                    stalled[c] < stall_len[c]) begin
                    stalled[c]++;
                    tx_valid[c] = 1'b0;
                end else begin
                    tx_valid[c] = (txq[c].size() > 0);
                end
                tx_data[c] = (txq[c].size() > 0) ? txq[c][0] : 8'h00;
            end
        end
    end

    task automatic request(input int c, input int slave, input int len,
                           input int first, input int nb,
                           input int exp_rx, input int exp_err);
        ev_t e;
        for (int i = 0; i < nb; i++) txq[c].push_back(8'((first + i) & 255));
        p_slave[c] = S'(slave);
        p_len[c] = 5'(len);
        req_cnt[c]++;
        e.kind = EV_G; e.idx = c; e.val = 0;
        sb.push_back(e);
        for (int i = 0; i < exp_rx; i++) begin
            e.kind = EV_RX; e.idx = c; e.val = (first + i) & 255;
            sb.push_back(e);
        end
        e.kind = EV_D; e.idx = c; e.val = exp_err;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk(nm, sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_write", int'(write), 0);
        chk("rst_read", int'(read), 0);
        chk("rst_strobe", int'(wstrb), 15);
        chk("rst_waddr", int'(waddr), int'(SPI_STATUS));
        chk("rst_raddr", int'(raddr), int'(SPI_STATUS));
        chk("rst_done", int'(done), 0);
        chk("rst_rxvalid", int'(rx_valid), 0);
        chk("rst_error", int'(error), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, w0;
        do_reset();

        // single client, 8 bytes 'A'..'H'
        request(0, 1, 8, 8'h41, 8, 8, 0);
        wait_done("t1_drain", 400);
        chk("t1_deselect", sel_last, 0);

        // all four together after a fresh reset: grants 0,1,2,3
        do_reset();
        request(0, 1, 2, 8'h10, 2, 2, 0);
        request(1, 1, 2, 8'h20, 2, 2, 0);
        request(2, 1, 2, 8'h30, 2, 2, 0);
        request(3, 1, 2, 8'h40, 2, 2, 0);
        wait_done("t2_drain", 800);

        // clients 3 and 0 together: pointer back at 0, so 0 first
        request(0, 1, 2, 8'h50, 2, 2, 0);
        request(3, 1, 2, 8'h60, 2, 2, 0);
        wait_done("t3_drain", 400);

        // maximum burst length
        request(0, 1, 16, 8'h80, 16, 16, 0);
        wait_done("t3b_drain", 600);

        // rejected requests: length 0, length 17, slave not one-hot
        a0 = n_acc;
        request(2, 1, 0, 0, 0, 0, 1);
        wait_done("t4a_drain", 50);
        request(2, 1, 17, 0, 0, 0, 1);
        wait_done("t4b_drain", 50);
        request(2, 0, 2, 0, 0, 0, 1);
        wait_done("t4c_drain", 50);
        chk("t4_no_access", n_acc - a0, 0);

        // client 1 stalls tx_valid for 5 cycles after 2 bytes
        w0 = tx_wr_cnt;
        tx_viol = 0;
        stall_at[1] = pops[1] + 2;
        stall_len[1] = 5;
        request(1, 1, 4, 8'hC0, 4, 4, 0);
        wait_done("t5_drain", 400);
        chk("t5_no_write_stalled", tx_viol, 0);
        chk("t5_tx_writes", tx_wr_cnt - w0, 4);
        stall_at[1] = -1;

        // write error on the third TX write
        inj_base = tx_wr_cnt;
        inj_en = 1'b1;
        request(3, 1, 4, 8'hE0, 4, 0, 1);
        wait_done("t6_drain", 400);
        inj_en = 1'b0;
        chk("t6_sel0", sel_last, 0);
        chk("t6_tx_writes", tx_wr_cnt - inj_base, 3);
        txq[3].delete();

        // a normal transaction afterwards still works
        request(2, 1, 3, 8'h70, 3, 3, 0);
        wait_done("t7_drain", 400);

`ifdef SPI_SCHED_TIMEOUT_EN
        irq_en = 1'b0;
        request(0, 1, 1, 8'h99, 1, 0, 1);
        wait_done("t8_timeout", 70000);
        irq_en = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
